// File: rtl/load_seq_pkg.sv
// Shared types and default widths for the storage load sequencer.
// Target and state encodings are visible on the host interface, so their values are fixed here.
package load_seq_pkg;

   localparam int DEF_DATA_W = 48;
   localparam int DEF_IDX_W  = 32;
   localparam int DEF_CODE_W = 12;
   localparam int DEF_CNT_W  = 16;
   localparam int N_TARGETS  = 4;

   typedef enum logic [1:0] {
      CODE   = 2'd0,
      WEIGHT = 2'd1,
      INPUT  = 2'd2,
      LABEL  = 2'd3
   } target_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      LOC_RST = 3'd2,
      CODE_EN = 3'd3,
      RUN     = 3'd4
   } state_e;

   // One-hot write select for a record target.
   function automatic logic [N_TARGETS-1:0] target_select(input target_e t);
      logic [N_TARGETS-1:0] sel;
      sel = '0;
      case (t)
         CODE:    sel[0] = 1'b1;
         WEIGHT:  sel[1] = 1'b1;
         INPUT:   sel[2] = 1'b1;
         LABEL:   sel[3] = 1'b1;
         default: sel = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/storage_write_port.sv
// One storage write interface: a registered address/data bus plus a one-cycle write strobe.
// The bus keeps its last written value between writes; only the strobe returns to zero.
module storage_write_port #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_is_write
);

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_is_write;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   // NOTE: the bus registers are reset too, because downstream sees them as defined outputs from reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_data     <= '0;
         r_is_write <= 1'b0;
      end else begin
         r_is_write <= i_wr;
         if (i_wr) begin
            r_addr <= i_addr;
            r_data <= i_data;
         end
      end
   end

   assign o_addr     = r_addr;
   assign o_data     = r_data;
   assign o_is_write = r_is_write;

endmodule

// File: rtl/storage_load_sequencer.sv
// Host-facing sequencer for data_path: steers load records to the four storage write ports,
// then sequences locator reset, code storage enable and controller enable in that order.
module storage_load_sequencer
   import load_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int CODE_W = DEF_CODE_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,

   input  logic              rec_valid,
   output logic              rec_ready,
   input  logic [1:0]        rec_target,
   input  logic [IDX_W-1:0]  rec_layer,
   input  logic [IDX_W-1:0]  rec_row,
   input  logic [DATA_W-1:0] rec_data,

   input  logic              cmd_load,
   input  logic              cmd_run,
   input  logic              cmd_stop,

   output logic [IDX_W-1:0]  code_storage_write_interface_write_line,
   output logic [CODE_W-1:0] code_storage_write_interface_write_data,
   output logic              code_storage_write_interface_is_write,

   output logic [IDX_W-1:0]  weight_storage_write_interface_write_layer_index,
   output logic [IDX_W-1:0]  weight_storage_write_interface_write_row_index,
   output logic [DATA_W-1:0] weight_storage_write_interface_write_data,
   output logic              weight_storage_is_write_interface_is_write,

   output logic [IDX_W-1:0]  input_storage_write_interface_write_layer_index,
   output logic [IDX_W-1:0]  input_storage_write_interface_write_row_index,
   output logic [DATA_W-1:0] input_storage_write_interface_write_data,
   output logic              input_storage_is_write_interface_is_write,

   output logic [IDX_W-1:0]  label_storage_write_interface_write_layer_index,
   output logic [IDX_W-1:0]  label_storage_write_interface_write_row_index,
   output logic [DATA_W-1:0] label_storage_write_interface_write_data,
   output logic              label_storage_is_write_interface_is_write,

   output logic              matrix_storage_locator_reset_interface_reset,
   output logic              code_storage_enable_interface_enable,
   output logic              controller_enable_interface_enable,
   output logic [2:0]        state_o,
   output logic [CNT_W-1:0]  write_count
);

   state_e                 r_state;
   state_e                 w_state_next;
   logic [CNT_W-1:0]       r_write_count;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_clear_count;
   logic [N_TARGETS-1:0]   w_sel;
   logic [2*IDX_W-1:0]     w_weight_addr;
   logic [2*IDX_W-1:0]     w_input_addr;
   logic [2*IDX_W-1:0]     w_label_addr;

   // ------------------------------------------------------------------
   // Run-control FSM. Stop beats run beats load; commands that do not
   // apply to the current state fall through to the default hold.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next  = r_state;
      w_ready       = 1'b0;
      w_clear_count = 1'b0;
      matrix_storage_locator_reset_interface_reset = 1'b0;
      code_storage_enable_interface_enable         = 1'b0;
      controller_enable_interface_enable           = 1'b0;

      case (r_state)
         IDLE: begin
            if (!cmd_stop && cmd_load) begin
               w_state_next  = LOAD;
               w_clear_count = 1'b1;
            end
         end
         LOAD: begin
            // A record offered alongside cmd_run is refused so nothing lands after the run starts.
            w_ready = !cmd_run;
            if (cmd_stop) begin
               w_state_next = IDLE;
            end else if (cmd_run) begin
               w_state_next = LOC_RST;
            end
         end
         LOC_RST: begin
            matrix_storage_locator_reset_interface_reset = 1'b1;
            w_state_next = cmd_stop ? IDLE : CODE_EN;
         end
         CODE_EN: begin
            code_storage_enable_interface_enable = 1'b1;
            w_state_next = cmd_stop ? IDLE : RUN;
         end
         RUN: begin
            code_storage_enable_interface_enable = 1'b1;
            controller_enable_interface_enable   = 1'b1;
            if (cmd_stop) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign rec_ready = w_ready;
   assign state_o   = r_state;
   assign w_accept  = rec_valid && w_ready;
   assign w_sel     = target_select(target_e'(rec_target));

   // ------------------------------------------------------------------
   // Saturating count of records accepted since the last cmd_load.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_write_count <= '0;
      end else if (w_clear_count) begin
         r_write_count <= '0;
      end else if (w_accept && (r_write_count != {CNT_W{1'b1}})) begin
         r_write_count <= r_write_count + 1'b1;
      end
   end

   assign write_count = r_write_count;

   // ------------------------------------------------------------------
   // Storage write ports. Code storage takes the row as its line and
   // only the low CODE_W data bits; the others carry {layer, row}.
   // ------------------------------------------------------------------
   storage_write_port #(
      .ADDR_W (IDX_W),
      .DATA_W (CODE_W)
   ) u_code_port (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .i_wr       (w_accept && w_sel[0]),
      .i_addr     (rec_row),
      .i_data     (rec_data[CODE_W-1:0]),
      .o_addr     (code_storage_write_interface_write_line),
      .o_data     (code_storage_write_interface_write_data),
      .o_is_write (code_storage_write_interface_is_write)
   );

   storage_write_port #(
      .ADDR_W (2*IDX_W),
      .DATA_W (DATA_W)
   ) u_weight_port (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .i_wr       (w_accept && w_sel[1]),
      .i_addr     ({rec_layer, rec_row}),
      .i_data     (rec_data),
      .o_addr     (w_weight_addr),
      .o_data     (weight_storage_write_interface_write_data),
      .o_is_write (weight_storage_is_write_interface_is_write)
   );

   storage_write_port #(
      .ADDR_W (2*IDX_W),
      .DATA_W (DATA_W)
   ) u_input_port (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .i_wr       (w_accept && w_sel[2]),
      .i_addr     ({rec_layer, rec_row}),
      .i_data     (rec_data),
      .o_addr     (w_input_addr),
      .o_data     (input_storage_write_interface_write_data),
      .o_is_write (input_storage_is_write_interface_is_write)
   );

   storage_write_port #(
      .ADDR_W (2*IDX_W),
      .DATA_W (DATA_W)
   ) u_label_port (
      .clk        (clk_clk),
      .rst_n      (reset_reset_n),
      .i_wr       (w_accept && w_sel[3]),
      .i_addr     ({rec_layer, rec_row}),
      .i_data     (rec_data),
      .o_addr     (w_label_addr),
      .o_data     (label_storage_write_interface_write_data),
      .o_is_write (label_storage_is_write_interface_is_write)
   );

   assign weight_storage_write_interface_write_layer_index = w_weight_addr[2*IDX_W-1:IDX_W];
   assign weight_storage_write_interface_write_row_index   = w_weight_addr[IDX_W-1:0];
   assign input_storage_write_interface_write_layer_index  = w_input_addr[2*IDX_W-1:IDX_W];
   assign input_storage_write_interface_write_row_index    = w_input_addr[IDX_W-1:0];
   assign label_storage_write_interface_write_layer_index  = w_label_addr[2*IDX_W-1:IDX_W];
   assign label_storage_write_interface_write_row_index    = w_label_addr[IDX_W-1:0];

endmodule

// File: tb/tb_storage_load_sequencer.sv
// Self-checking bench: directed literal checks plus randomized traffic compared every cycle
// against a transaction-level model of the sequencer (write counter narrowed to 4 bits).
module tb_storage_load_sequencer;

   localparam int DATA_W = 48;
   localparam int IDX_W  = 32;
   localparam int CODE_W = 12;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rec_valid = 1'b0;
   logic              rec_ready;
   logic [1:0]        rec_target = '0;
   logic [IDX_W-1:0]  rec_layer = '0;
   logic [IDX_W-1:0]  rec_row = '0;
   logic [DATA_W-1:0] rec_data = '0;
   logic              cmd_load = 1'b0;
   logic              cmd_run = 1'b0;
   logic              cmd_stop = 1'b0;

   logic [IDX_W-1:0]  code_line;
   logic [CODE_W-1:0] code_data;
   logic              code_wr;
   logic [IDX_W-1:0]  weight_layer, weight_row, input_layer, input_row, label_layer, label_row;
   logic [DATA_W-1:0] weight_data, input_data, label_data;
   logic              weight_wr, input_wr, label_wr;
   logic              loc_rst, code_en, ctrl_en;
   logic [2:0]        state_o;
   logic [CNT_W-1:0]  write_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit compare_on = 1'b0;

   storage_load_sequencer #(
      .DATA_W (DATA_W), .IDX_W (IDX_W), .CODE_W (CODE_W), .CNT_W (CNT_W)
   ) dut (
      .clk_clk                                          (clk),
      .reset_reset_n                                    (rst_n),
      .rec_valid                                        (rec_valid),
      .rec_ready                                        (rec_ready),
      .rec_target                                       (rec_target),
      .rec_layer                                        (rec_layer),
      .rec_row                                          (rec_row),
      .rec_data                                         (rec_data),
      .cmd_load                                         (cmd_load),
      .cmd_run                                          (cmd_run),
      .cmd_stop                                         (cmd_stop),
      .code_storage_write_interface_write_line          (code_line),
      .code_storage_write_interface_write_data          (code_data),
      .code_storage_write_interface_is_write            (code_wr),
      .weight_storage_write_interface_write_layer_index (weight_layer),
      .weight_storage_write_interface_write_row_index   (weight_row),
      .weight_storage_write_interface_write_data        (weight_data),
      .weight_storage_is_write_interface_is_write       (weight_wr),
      .input_storage_write_interface_write_layer_index  (input_layer),
      .input_storage_write_interface_write_row_index    (input_row),
      .input_storage_write_interface_write_data         (input_data),
      .input_storage_is_write_interface_is_write        (input_wr),
      .label_storage_write_interface_write_layer_index  (label_layer),
      .label_storage_write_interface_write_row_index    (label_row),
      .label_storage_write_interface_write_data         (label_data),
      .label_storage_is_write_interface_is_write        (label_wr),
      .matrix_storage_locator_reset_interface_reset     (loc_rst),
      .code_storage_enable_interface_enable             (code_en),
      .controller_enable_interface_enable               (ctrl_en),
      .state_o                                          (state_o),
      .write_count                                      (write_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: phase number, record count, and per-target
   // "last written" address/data plus "written in the previous cycle".
   // ------------------------------------------------------------------
   int          m_phase = 0;              // 0 idle, 1 load, 2 locator reset, 3 code only, 4 running
   int          m_count = 0;
   bit          m_wr   [4] = '{0, 0, 0, 0};
   logic [63:0] m_addr [4] = '{0, 0, 0, 0};
   logic [63:0] m_data [4] = '{0, 0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_count = 0;
         for (int k = 0; k < 4; k++) begin
            m_wr[k] = 0; m_addr[k] = '0; m_data[k] = '0;
         end
      end else begin
         bit accept;
         int t;
         accept = rec_valid && (m_phase == 1) && !cmd_run;
         t = int'(rec_target);
         for (int k = 0; k < 4; k++) m_wr[k] = 0;
         if (accept) begin
            m_wr[t] = 1;
            m_addr[t] = (t == 0) ? 64'(rec_row) : {rec_layer, rec_row};
            m_data[t] = (t == 0) ? 64'(rec_data[CODE_W-1:0]) : 64'(rec_data);
            if (m_count < CNT_MAX) m_count = m_count + 1;
         end
         if (cmd_stop) m_phase = 0;
         else if (m_phase == 1 && cmd_run) m_phase = 2;
         else if (m_phase == 0 && cmd_load) begin
            m_phase = 1;
            m_count = 0;
         end
         else if (m_phase == 2 || m_phase == 3) m_phase = m_phase + 1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (rst_n && compare_on) begin
         logic [3:0]  a_wr;
         logic [63:0] a_addr [4];
         logic [63:0] a_data [4];
         a_wr = {label_wr, input_wr, weight_wr, code_wr};
         a_addr[0] = 64'(code_line);
         a_addr[1] = {weight_layer, weight_row};
         a_addr[2] = {input_layer, input_row};
         a_addr[3] = {label_layer, label_row};
         a_data[0] = 64'(code_data);
         a_data[1] = 64'(weight_data);
         a_data[2] = 64'(input_data);
         a_data[3] = 64'(label_data);
         check("model_state", 64'(state_o), 64'(m_phase));
         check("model_ready", 64'(rec_ready), 64'((m_phase == 1) && !cmd_run));
         check("model_loc_rst", 64'(loc_rst), 64'(m_phase == 2));
         check("model_code_en", 64'(code_en), 64'(m_phase == 3 || m_phase == 4));
         check("model_ctrl_en", 64'(ctrl_en), 64'(m_phase == 4));
         check("model_count", 64'(write_count), 64'(m_count));
         for (int k = 0; k < 4; k++) begin
            check($sformatf("model_is_write_%0d", k), 64'(a_wr[k]), 64'(m_wr[k]));
            check($sformatf("model_addr_%0d", k), a_addr[k], m_addr[k]);
            check($sformatf("model_data_%0d", k), a_data[k], m_data[k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rec(input bit v, input int t, input int unsigned layer, input int unsigned row,
                          input logic [DATA_W-1:0] data);
      rec_valid  = v;
      rec_target = 2'(t);
      rec_layer  = layer;
      rec_row    = row;
      rec_data   = data;
   endtask

   initial begin
      logic [63:0] rnd;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_on = 1'b1;

      // Reset values.
      @(negedge clk);
      check("rst_state", 64'(state_o), 64'd0);
      check("rst_count", 64'(write_count), 64'd0);
      check("rst_weight_data", 64'(weight_data), 64'd0);
      check("rst_enables", 64'({loc_rst, code_en, ctrl_en}), 64'd0);

      // Load, then one weight record.
      cmd_load = 1'b1;
      step();
      cmd_load = 1'b0;
      set_rec(1, 1, 1, 2, 48'h0001_0002_0003);
      step();
      set_rec(0, 0, 0, 0, '0);
      @(negedge clk);
      check("w1_is_write", 64'(weight_wr), 64'd1);
      check("w1_layer", 64'(weight_layer), 64'd1);
      check("w1_row", 64'(weight_row), 64'd2);
      check("w1_data", 64'(weight_data), 64'h0001_0002_0003);
      check("w1_other_strobes", 64'({code_wr, input_wr, label_wr}), 64'd0);
      check("w1_count", 64'(write_count), 64'd1);

      // Four back-to-back records walking the targets.
      for (int i = 0; i < 4; i++) begin
         set_rec(1, i, 7, 5, 48'h0000_0000_0ABC);
         step();
         @(negedge clk);
         check($sformatf("walk_strobe_%0d", i), 64'({label_wr, input_wr, weight_wr, code_wr}),
               64'(4'b0001 << i));
      end
      set_rec(0, 0, 0, 0, '0);
      check("walk_code_line", 64'(code_line), 64'd5);
      check("walk_code_data", 64'(code_data), 64'hABC);
      check("walk_count", 64'(write_count), 64'd5);

      // cmd_run with a record offered: refused, then the start sequence.
      set_rec(1, 2, 9, 9, 48'h1234);
      cmd_run = 1'b1;
      #1;
      check("run_ready_low", 64'(rec_ready), 64'd0);
      step();
      cmd_run = 1'b0;
      set_rec(0, 0, 0, 0, '0);
      @(negedge clk);
      check("run_loc_rst", 64'({loc_rst, code_en, ctrl_en}), 64'b100);
      check("run_no_write", 64'(input_wr), 64'd0);
      check("run_count_held", 64'(write_count), 64'd5);
      step();
      @(negedge clk);
      check("run_code_en", 64'({loc_rst, code_en, ctrl_en}), 64'b010);
      step();
      @(negedge clk);
      check("run_ctrl_en", 64'({loc_rst, code_en, ctrl_en}), 64'b011);

      // Stop, then a stray cmd_run in IDLE.
      cmd_stop = 1'b1;
      step();
      cmd_stop = 1'b0;
      @(negedge clk);
      check("stop_enables", 64'({code_en, ctrl_en}), 64'd0);
      check("stop_state", 64'(state_o), 64'd0);
      cmd_run = 1'b1;
      step();
      cmd_run = 1'b0;
      @(negedge clk);
      check("idle_run_ignored", 64'({state_o, loc_rst}), 64'd0);

      // Saturation of the 4-bit counter.
      cmd_load = 1'b1;
      step();
      cmd_load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         set_rec(1, int'($urandom_range(0, 3)), $urandom, $urandom, 48'(i));
         step();
      end
      set_rec(0, 0, 0, 0, '0);
      @(negedge clk);
      check("sat_count", 64'(write_count), 64'd15);

      // Reset right after a handshake kills the strobe at once.
      set_rec(1, 1, 3, 4, 48'hBEEF);
      step();
      set_rec(0, 0, 0, 0, '0);
      check("pre_rst_strobe", 64'(weight_wr), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_strobe", 64'(weight_wr), 64'd0);
      check("rst_async_state", 64'(state_o), 64'd0);
      check("rst_async_count", 64'(write_count), 64'd0);
      check("rst_async_bus", {weight_layer, weight_row}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         step();
         rnd = {$urandom, $urandom};
         set_rec($urandom_range(0, 9) < 6, int'($urandom_range(0, 3)), $urandom, $urandom,
                 rnd[DATA_W-1:0]);
         cmd_load = ($urandom_range(0, 9) == 0);
         cmd_run  = ($urandom_range(0, 19) == 0);
         cmd_stop = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
      end
      step();
      set_rec(0, 0, 0, 0, '0);
      {cmd_load, cmd_run, cmd_stop} = 3'b000;
      @(negedge clk);
      @(negedge clk);
      compare_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
